// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_if
// Brief    : Control and fetch-address bundle between the requester and pc_unit.
// Revision : 1.0
// ============================================================================
interface pc_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              branch_en;
    logic [7:0]        branch_off;
    logic              halt;
    logic [ADDR_W-1:0] Read_Addr;
    logic              fetch_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output start, stall, jump_en, jump_addr, branch_en, branch_off, halt,
        input  Read_Addr, fetch_valid, halted, fetch_count
    );

    modport slave (
        input  start, stall, jump_en, jump_addr, branch_en, branch_off, halt,
        output Read_Addr, fetch_valid, halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter feeding the instruction register: stall, branch,
//            jump, halt and a saturating fetch counter. All outputs registered.
// Revision : 1.0
// ============================================================================
module pc_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    pc_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_valid;
    logic               r_halted;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_valid;
    logic               w_halted;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic [ADDR_W-1:0]  w_offset;

    // Counter clamps at all-ones rather than wrapping.
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    assign w_offset    = {{(ADDR_W-8){bus.branch_off[7]}}, bus.branch_off};

    always_comb begin
        w_state  = r_state;
        w_addr   = r_addr;
        w_valid  = r_valid;
        w_halted = r_halted;
        w_count  = r_count;
        case (r_state)
            IDLE: begin
                w_addr   = '0;
                w_valid  = 1'b0;
                w_halted = 1'b0;
                if (bus.start) begin
                    w_state = RUN;
                    w_valid = 1'b1;
                    w_count = w_count_inc;
                end
            end
            RUN: begin
                w_valid  = 1'b1;
                w_halted = 1'b0;
                if (bus.halt) begin
                    w_state  = HALT;
                    w_valid  = 1'b0;
                    w_halted = 1'b1;
                end else if (!bus.stall) begin
                    w_count = w_count_inc;
                    if (bus.jump_en) begin
                        w_addr = bus.jump_addr;
                    end else if (bus.branch_en) begin
                        w_addr = r_addr + ADDR_W'(1) + w_offset;
                    end else begin
                        w_addr = r_addr + ADDR_W'(1);
                    end
                end
            end
            HALT: begin
                w_valid  = 1'b0;
                w_halted = 1'b1;
            end
            default: begin
                // Illegal encoding: fall back to a clean IDLE.
                w_state  = IDLE;
                w_addr   = '0;
                w_valid  = 1'b0;
                w_halted = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state;
            r_addr   <= w_addr;
            r_valid  <= w_valid;
            r_halted <= w_halted;
            r_count  <= w_count;
        end
    end

    assign bus.Read_Addr   = r_addr;
    assign bus.fetch_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_count;

endmodule
`default_nettype wire
